// File: rtl/onchip_mem_arb_pkg.sv
// Shared types and constants for the two-requester on-chip RAM arbiter.
// The optional grant-lock feature is enabled by defining ONCHIP_ARB_LOCK_EN.
package onchip_mem_arb_pkg;

  // Arbiter FSM: plain round-robin, or grant held for one requester.
  typedef enum logic [1:0] {
    RR    = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  // Requester indices, also the encoding of last_grant and rd_owner.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 32;

endpackage

// File: rtl/onchip_mem_arb_rr_arb2.sv
// Combinational 2-way round-robin pick. A lone requester always wins, a tie
// goes to the requester that was not granted last, and a lock state only lets
// the locking requester through.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  arb_state_t state_i,
  output logic [1:0] grant_o
);

  // One-hot (or zero) grant from request, history and lock state.
  always_comb begin
    grant_o = 2'b00;
    case (state_i)
      LOCK0:   grant_o = {1'b0, req_i[0]};
      LOCK1:   grant_o = {req_i[1], 1'b0};
      default: begin
        if (req_i == 2'b11) grant_o = (last_grant_i == M1) ? 2'b01 : 2'b10;
        else                grant_o = req_i;
      end
    endcase
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-requester Avalon-MM arbiter for a single-port on-chip RAM with a fixed
// read latency of one cycle. Define ONCHIP_ARB_LOCK_EN to let a requester
// hold the grant across transfers via mX_lock; otherwise mX_lock is ignored.
//
// Handshake: a requester asserts mX_read or mX_write (write wins if both) and
// must hold its request stable while mX_waitrequest=1; the transfer is
// accepted in the cycle mX_waitrequest=0. Read data returns exactly one cycle
// after accept with mX_readdatavalid=1, never stalled.
module onchip_mem_arbiter
  import onchip_mem_arb_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic              m0_lock,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic              m1_lock,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  input  logic              clken,
  input  logic              reset_req,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output arb_state_t        dbg_state
);

  arb_state_t state_q;
  logic       last_grant_q;
  logic       rd_pend_q;
  logic       rd_owner_q;

  logic       issue_ok;
  logic [1:0] req;
  logic [1:0] grant;
  logic       win;
  logic       accept;
  logic       rd_accept;

  // Requests only count when the RAM is clocked and no reset is pending.
  assign issue_ok = clken & ~reset_req;
  assign req      = {m1_read | m1_write, m0_read | m0_write} & {2{issue_ok}};

  rr_arb2 u_arb (
    .req_i       (req),
    .last_grant_i(last_grant_q),
    .state_i     (state_q),
    .grant_o     (grant)
  );

  assign win       = grant[1];
  assign accept    = |grant;
  assign rd_accept = accept & ~mem_write;

  assign m0_waitrequest = ~grant[0];
  assign m1_waitrequest = ~grant[1];

  // Winner's command muxed onto the RAM port.
  assign mem_chipselect = accept;
  assign mem_address    = win ? m1_address    : m0_address;
  assign mem_byteenable = win ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = win ? m1_writedata  : m0_writedata;
  assign mem_write      = accept & (win ? m1_write : m0_write);
  assign mem_clken      = issue_ok;

  // Read data is steered to the issuing requester; the other sees zero.
  assign m0_readdatavalid = rd_pend_q & (rd_owner_q == M0);
  assign m1_readdatavalid = rd_pend_q & (rd_owner_q == M1);
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

  assign dbg_state = state_q;

  // Arbitration history and one-deep read tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= M1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= M0;
    end else begin
      if (accept)    last_grant_q <= win;
      rd_pend_q <= rd_accept;
      if (rd_accept) rd_owner_q   <= win;
    end
  end

`ifdef ONCHIP_ARB_LOCK_EN
  // Lock FSM: an accepted transfer with lock set holds the grant for its owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RR;
    end else if (grant[0]) begin
      state_q <= m0_lock ? LOCK0 : RR;
    end else if (grant[1]) begin
      state_q <= m1_lock ? LOCK1 : RR;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;

  // Lock feature absent: the FSM stays in round-robin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RR;
    else          state_q <= RR;
  end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle RAM and a
// read-return scoreboard. Honors ONCHIP_ARB_LOCK_EN for the lock scenario.
module tb_onchip_mem_arbiter;
  import onchip_mem_arb_pkg::*;

  localparam int AW = 2;
  localparam int DW = 32;
  localparam int BW = 4;

  logic          clk, reset_n;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m0_lock, m1_read, m1_write, m1_lock;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          clken, reset_req;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata, mem_readdata;
  arb_state_t    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];   // {owner, data}
  logic [DW:0] mon_e;
  logic        mon_owner;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_lock(m0_lock),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_lock(m1_lock),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .clken(clken), .reset_req(reset_req),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .dbg_state(dbg_state)
  );

  // Behavioural RAM: registered address, q valid the cycle after accept.
  logic [DW-1:0] ram [4];
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input bit lk);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be;
      m0_writedata = wd; m0_lock = lk;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be;
      m1_writedata = wd; m1_lock = lk;
    end
  endtask

  task automatic idle(input int m);
    drive(m, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One uncontended transfer; a read pushes its hand-computed result.
  task automatic single(input int m, input bit wr, input logic [1:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input string name);
    drive(m, !wr, wr, a, be, wd, 1'b0);
    @(negedge clk);
    chk({name, "_wait"}, (m == 0) ? m0_waitrequest : m1_waitrequest, 0);
    chk({name, "_cs"}, mem_chipselect, 1);
    chk({name, "_addr"}, mem_address, a);
    if (!wr) exp_q.push_back({(m == 1), exp_rd});
    tick();
    idle(m);
  endtask

  // Monitor: compare every read return against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (m0_readdatavalid && m1_readdatavalid) begin
          checks++; errors++;
          $display("FAIL rdv_both: got 2 valid strobes expected 1");
        end else if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rdv_unexpected: got m%0d valid data %h expected none",
                   m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata);
        end else begin
          mon_e = exp_q.pop_front();
          mon_owner = m1_readdatavalid;
          chk("rd_owner", {31'b0, mon_owner}, {31'b0, mon_e[DW]});
          chk("rd_data", mon_owner ? m1_readdata : m0_readdata, mon_e[DW-1:0]);
          chk("rd_other_zero", mon_owner ? m0_readdata : m1_readdata, 32'h0);
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle(0); idle(1);
    @(negedge clk);
    chk("rst_rdv0", m0_readdatavalid, 0);
    chk("rst_rdv1", m1_readdatavalid, 0);
    chk("rst_rd0", m0_readdata, 0);
    chk("rst_cs", mem_chipselect, 0);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, RR});
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Single requester write then read; then write/read back-to-back.
    single(0, 1'b1, 2'd2, 4'hF, 32'hDEADBEEF, 32'h0, "wr_a2");
    single(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'hDEADBEEF, "rd_a2");
    tick(); tick();
    single(0, 1'b1, 2'd2, 4'hF, 32'h12345678, 32'h0, "wr_b2b");
    single(0, 1'b0, 2'd2, 4'hF, 32'h0, 32'h12345678, "rd_b2b");
    tick();

    // Preloads and byte-enable merge.
    single(0, 1'b1, 2'd0, 4'hF, 32'h0000AAAA, 32'h0, "wr_a0");
    single(1, 1'b1, 2'd3, 4'hF, 32'h0000BBBB, 32'h0, "wr_a3");
    single(0, 1'b1, 2'd1, 4'hF, 32'h11223344, 32'h0, "wr_a1");
    single(1, 1'b1, 2'd1, 4'h5, 32'hAABBCCDD, 32'h0, "wr_be");
    single(1, 1'b0, 2'd1, 4'hF, 32'h0, 32'h11BB33DD, "rd_be");
    tick();

    // Reset, then continuous contention: m0 first, then strict alternation.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b0, 2'd0, 4'hF, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 2'd3, 4'hF, 32'h0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_wait0", m0_waitrequest, (k % 2));
      chk("cont_wait1", m1_waitrequest, 1 - (k % 2));
      exp_q.push_back((k % 2 == 0) ? {1'b0, 32'h0000AAAA} : {1'b1, 32'h0000BBBB});
      tick();
    end
    idle(0); idle(1);
    tick(); tick();

    // Stall on clken=0, then on reset_req=1.
    for (int s = 0; s < 2; s++) begin
      drive(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0, 1'b0);
      if (s == 0) clken = 1'b0; else reset_req = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("stall_wait0", m0_waitrequest, 1);
        chk("stall_cs", mem_chipselect, 0);
        chk("stall_clken", mem_clken, 0);
        tick();
      end
      clken = 1'b1; reset_req = 1'b0;
      @(negedge clk);
      chk("stall_accept", m0_waitrequest, 0);
      exp_q.push_back({1'b0, 32'h12345678});
      tick();
      idle(0);
      tick(); tick();
    end

    // Reset while a read is outstanding discards it.
    drive(0, 1'b1, 1'b0, 2'd2, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("rstrd_accept", m0_waitrequest, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    idle(0);
    @(negedge clk);
    chk("rstrd_rdv0", m0_readdatavalid, 0);
    chk("rstrd_rdv1", m1_readdatavalid, 0);
    tick(); tick();
    reset_n = 1'b1;
    drive(0, 1'b1, 1'b0, 2'd0, 4'hF, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 2'd3, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    chk("tie_wait0", m0_waitrequest, 0);
    chk("tie_wait1", m1_waitrequest, 1);
    exp_q.push_back({1'b0, 32'h0000AAAA});
    tick();
    idle(0);
    @(negedge clk);
    chk("tie2_wait1", m1_waitrequest, 0);
    exp_q.push_back({1'b1, 32'h0000BBBB});
    tick();
    idle(1);
    tick();

    // Lock: m1 writes with lock, then idles while m0 requests.
    drive(1, 1'b0, 1'b1, 2'd3, 4'hF, 32'h0000BBBB, 1'b1);
    @(negedge clk);
    chk("lock_wr_wait1", m1_waitrequest, 0);
    tick();
    idle(1);
    drive(0, 1'b1, 1'b0, 2'd0, 4'hF, 32'h0, 1'b0);
`ifdef ONCHIP_ARB_LOCK_EN
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("lock_wait0", m0_waitrequest, 1);
      chk("lock_state", {30'b0, dbg_state}, {30'b0, LOCK1});
      tick();
    end
    drive(1, 1'b0, 1'b1, 2'd3, 4'hF, 32'h0000BBBB, 1'b0);
    @(negedge clk);
    chk("unlock_wait1", m1_waitrequest, 0);
    chk("unlock_wait0", m0_waitrequest, 1);
    tick();
    idle(1);
    @(negedge clk);
    chk("after_unlock_wait0", m0_waitrequest, 0);
    chk("after_unlock_state", {30'b0, dbg_state}, {30'b0, RR});
`else
    @(negedge clk);
    chk("nolock_wait0", m0_waitrequest, 0);
    chk("nolock_state", {30'b0, dbg_state}, {30'b0, RR});
`endif
    exp_q.push_back({1'b0, 32'h0000AAAA});
    tick();
    idle(0);
    tick(); tick(); tick();

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-requester Avalon-MM arbiter and sequencer for the 4-word × 32-bit single-port on-chip RAM in the NIOS SoC. It shares the one RAM port between the NIOS data master (m0) and a second requester (m1), such as a DMA or accelerator. It drives the RAM's chipselect, write, byteenable and clock-enable, tracks the 1-cycle read latency, and returns read data with readdatavalid to the issuing requester only.

## Interface
- ADDR_W, 2: word address width; RAM depth is 2**ADDR_W.
- DATA_W, 32: data width; BE_W = DATA_W/8 is derived, not overridable.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous reset, active-low
- mX_address  in  ADDR_W  requester X word address (X = 0,1)
- mX_byteenable  in  BE_W  requester X byte enables
- mX_read  in  1  read request
- mX_write  in  1  write request
- mX_writedata  in  DATA_W  write data
- mX_lock  in  1  hold grant after this transfer (only with ONCHIP_ARB_LOCK_EN)
- mX_waitrequest  out  1  request not accepted this cycle
- mX_readdata  out  DATA_W  read data
- mX_readdatavalid  out  1  mX_readdata valid
- clken  in  1  system clock enable
- reset_req  in  1  reset-request hold-off from the reset controller
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken
- mem_readdata  in  DATA_W  RAM q, valid the cycle after the address is accepted

## Operation
- Requester X requests when mX_read or mX_write is high. If both are high, the transfer is a write and the read is dropped.
- Issue is allowed only when clken=1 and reset_req=0. Otherwise both mX_waitrequest are 1 and mem_chipselect is 0.
- Round-robin arbitration uses register last_grant:
  - a single requester always wins;
  - when both request, the requester that is not last_grant wins;
  - last_grant updates on every accepted transfer.
- The winner's address, byteenable, writedata and write flag are muxed combinationally onto mem_*. The winner sees mX_waitrequest=0; the loser sees 1.
- One transfer is accepted per cycle. Back-to-back transfers are allowed, including a read immediately after a write to the same address.
- On an accepted read, rd_pend←1 and rd_owner←X. In the next cycle, m[rd_owner]_readdatavalid=1 and its readdata=mem_readdata. The other requester sees readdatavalid=0 and readdata=0.
- Read return is never stalled. The RAM address register captured the address while clken was 1, so the returned data is valid.
- mem_clken = clken & ~reset_req.
- A requester must hold its request signals stable while its waitrequest is 1.
- Reset state: last_grant=1, so m0 wins the first tie. rd_pend=0, rd_owner=0, readdatavalid=0, readdata=0, mem_chipselect=0.
- A reset during an outstanding read discards the read; no readdatavalid is produced.

## Timing
- Accept cycle N: request high, grant, waitrequest=0 (combinational from registered state and request inputs).
- Read data: cycle N+1. Read latency is fixed at 1.
- Write: complete at the clock edge ending cycle N.
- Sustained throughput: 1 transfer per clock, shared between requesters. With both requesting continuously, each gets every other cycle.
- No combinational path from mem_readdata to any waitrequest.

## Configuration
- ONCHIP_ARB_LOCK_EN defined:
  - FSM has states RR, LOCK0, LOCK1.
  - RR→LOCKX when X's transfer is accepted with mX_lock=1.
  - In LOCKX, only X can be granted; the other requester waits even if X is idle.
  - LOCKX→RR when X's transfer is accepted with mX_lock=0.
  - Reset state is RR.
- ONCHIP_ARB_LOCK_EN undefined:
  - mX_lock is ignored; the FSM is permanently RR.
  - The lock ports remain present so the interface does not change.

## Structure
- Package onchip_mem_arb_pkg holds:
  - the arb_state_t enum (RR, LOCK0, LOCK1);
  - requester-index constants M0=0, M1=1;
  - default widths ADDR_W_DEF=2 and DATA_W_DEF=32.
- One sub-module, rr_arb2: combinational 2-way round-robin pick from req[1:0], last_grant and lock state, producing grant[1:0]. The top level holds all registers and the mem_* muxes.

## Test plan
- Single-requester write/read: m0 writes 0xDEADBEEF to addr 2 with be=0xF, then reads addr 2 → m0_readdatavalid one cycle after accept, data 0xDEADBEEF. m1_readdatavalid stays 0.
- Contention: from reset, m0 and m1 both read continuously → grants alternate m0,m1,m0,…; each readdatavalid pulses on alternate cycles with data from its own address.
- Byte enables: word 0x11223344 at addr 1; m1 writes 0xAABBCCDD with be=0x5; read addr 1 → 0x11BB33DD.
- Stall: clken=0 for 3 cycles while m0 reads → m0_waitrequest=1 and mem_chipselect=0 throughout; the read is accepted in the first cycle clken=1, data valid the next cycle. reset_req=1 gives the same result.
- Reset mid-read: reset_n low in the cycle after accept → no readdatavalid. After release, the first tie goes to m0.
- Lock (with ONCHIP_ARB_LOCK_EN): m1 writes with lock=1, then idles 2 cycles while m0 requests → m0 waits. m1's next write with lock=0 is accepted, then m0 is granted the following cycle. Without the macro, m0 is granted in the first idle cycle.
